iir_hpf: RTL and testbench
==========================

IIR_HPF -- requirements
Module: iir_hpf

Interface
REQ-001 Parameter COEF, default 16'sd32113, signed Q1.15 feedback coefficient a (≈0.98).
REQ-002 Parameter FRAC, default 15, product right-shift amount.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 input_a  input  32  signed sample from the upstream file-reader stream.
REQ-006 input_a_stb  input  1  upstream sample valid.
REQ-007 input_a_ack  output  1  block ready to accept input_a.
REQ-008 output_z  output  32  signed filtered sample.
REQ-009 output_z_stb  output  1  output_z valid.
REQ-010 output_z_ack  input  1  downstream accepted output_z.
REQ-011 sat  output  1  sticky flag, set when any output saturated; cleared only by rst.

Function
REQ-012 The filter SHALL compute y[n] = sat32((y[n-1] + x[n] - x[n-1]) * COEF >>> FRAC), where x[-1] = y[-1] = 0.
REQ-013 The FSM SHALL have exactly four states: GET, CALC, MUL, PUT.
REQ-014 In GET, input_a_ack SHALL be 1; at an edge with input_a_stb=1 and input_a_ack=1, the block SHALL latch x=input_a, drive input_a_ack to 0, and go to CALC.
REQ-015 In CALC, the block SHALL compute sum = y_prev + x - x_prev at 34-bit signed width with no wrap, and go to MUL.
REQ-016 In MUL, the block SHALL form a 50-bit signed product sum*COEF and arithmetic-shift it right by FRAC, truncating toward negative infinity.
REQ-017 In MUL, a shifted result above 32'h7FFFFFFF SHALL clamp to 32'h7FFFFFFF, a result below 32'h80000000 SHALL clamp to 32'h80000000, and any clamp SHALL set sat.
REQ-018 In MUL, the block SHALL register the result into output_z, set output_z_stb=1, and go to PUT.
REQ-019 Latency: for an input accepted at edge N, output_z_stb SHALL be 1 after edge N+2.
REQ-020 In PUT, output_z and output_z_stb SHALL hold stable until an edge with output_z_ack=1; input_a_ack SHALL stay 0 throughout PUT (no input accepted while output pending).
REQ-021 At the PUT edge with output_z_ack=1, the block SHALL clear output_z_stb, update x_prev<=x and y_prev<=output_z, set input_a_ack=1, and return to GET; the earliest next accept is the following edge (minimum 4 cycles per sample).
REQ-022 output_z_ack asserted outside PUT SHALL be ignored; input_a_stb outside GET SHALL be ignored, and its data SHALL NOT be latched.
REQ-023 History (x_prev, y_prev) SHALL update only on output handshake completion, so a stalled output never corrupts state.

Reset
REQ-024 On rst=1 at any edge, in any state, the block SHALL set state to GET, input_a_ack=1, output_z_stb=0, output_z=0, sat=0, x_prev=0, y_prev=0.
REQ-025 Reset SHALL abandon any in-flight sample; the pending output SHALL NOT be presented after reset.

Verification
REQ-026 Reset: assert rst 2 cycles -> input_a_ack=1, output_z_stb=0, output_z=0, sat=0.
REQ-027 Step, default COEF: from reset, inputs 1000 then 1000, ack immediately -> output_z=980 then 960; each stb rises 2 edges after its accept; sat=0.
REQ-028 Negative truncation: from reset, input -1000 -> output_z=-981.
REQ-029 Stall: output_z_ack held 0 for 10 cycles after output 980 -> output_z_stb stays 1, output_z stays 980, input_a_ack stays 0, the next input (1000) is not accepted; after ack, the next output is still 960.
REQ-030 Saturation, COEF=-16'sd32768: from reset, input 32'h80000000 -> output_z=32'h7FFFFFFF, sat=1 and remains 1 across later non-saturating samples until rst.
REQ-031 Reset mid-operation: rst asserted while in PUT with output_z_stb=1 -> after the reset edge, output_z_stb=0 and input_a_ack=1; a next input of 1000 yields 980, showing the history was cleared.

Source files
------------

// File: rtl/iir_hpf.sv
// First-order high-pass IIR, y[n] = sat32((y[n-1] + x[n] - x[n-1]) * a).
// Stream handshake on input and output; history advances only on output accept.
module iir_hpf #(
  parameter logic signed [15:0] COEF = 16'sd32113,
  parameter int                 FRAC = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack,
  output logic        sat
);

  typedef enum logic [1:0] {
    GET,
    CALC,
    MUL,
    PUT
  } state_t;

  localparam logic signed [49:0] ZMAX = 50'sd2147483647;
  localparam logic signed [49:0] ZMIN = -50'sd2147483648;

  state_t state;
  state_t state_n;

  logic signed [31:0] x;
  logic signed [31:0] x_prev;
  logic signed [31:0] y_prev;
  logic signed [31:0] z;
  logic signed [33:0] sum;
  logic signed [33:0] sum_n;
  logic signed [49:0] prod;
  logic signed [49:0] shifted;
  logic signed [31:0] clamped;
  logic               clip;

  always_comb begin
    sum_n = {{2{y_prev[31]}}, y_prev}
          + {{2{x[31]}}, x}
          - {{2{x_prev[31]}}, x_prev};
  end

  // Full-width signed product; >>> floors toward negative infinity.
  always_comb begin
    prod    = {{16{sum[33]}}, sum} * {{34{COEF[15]}}, COEF};
    shifted = prod >>> FRAC;
    clip    = 1'b0;
    clamped = shifted[31:0];
    if (shifted > ZMAX) begin
      clamped = 32'sh7FFFFFFF;
      clip    = 1'b1;
    end else if (shifted < ZMIN) begin
      clamped = 32'sh80000000;
      clip    = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      GET:  if (input_a_stb) state_n = CALC;
      CALC: state_n = MUL;
      MUL:  state_n = PUT;
      PUT:  if (output_z_ack) state_n = GET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= GET;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x      <= '0;
      x_prev <= '0;
      y_prev <= '0;
      z      <= '0;
      sum    <= '0;
      sat    <= 1'b0;
    end else begin
      unique case (state)
        GET:  if (input_a_stb) x <= input_a;
        CALC: sum <= sum_n;
        MUL: begin
          z <= clamped;
          if (clip) sat <= 1'b1;
        end
        PUT: if (output_z_ack) begin
          x_prev <= x;
          y_prev <= z;
        end
      endcase
    end
  end

  assign input_a_ack  = (state == GET);
  assign output_z_stb = (state == PUT);
  assign output_z     = z;

endmodule

// File: tb/tb_iir_hpf.sv
// Directed bench for iir_hpf: default-coef and saturating-coef instances
// share all inputs, so their handshakes run in lockstep.
module tb_iir_hpf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_stb = 1'b0;
  logic        z_ack = 1'b0;

  logic        ack_a, stb_a, sat_a;
  logic [31:0] z_a;
  logic        ack_b, stb_b, sat_b;
  logic [31:0] z_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  iir_hpf u_a (
    .clk          (clk),
    .rst          (rst),
    .input_a      (in_data),
    .input_a_stb  (in_stb),
    .input_a_ack  (ack_a),
    .output_z     (z_a),
    .output_z_stb (stb_a),
    .output_z_ack (z_ack),
    .sat          (sat_a)
  );

  iir_hpf #(.COEF(-16'sd32768), .FRAC(15)) u_b (
    .clk          (clk),
    .rst          (rst),
    .input_a      (in_data),
    .input_a_stb  (in_stb),
    .input_a_ack  (ack_b),
    .output_z     (z_b),
    .output_z_stb (stb_b),
    .output_z_ack (z_ack),
    .sat          (sat_b)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h (%0d) expected %0h (%0d)",
               tag, got, $signed(got), exp, $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Offer d until accepted, then wait for the output strobe and check latency.
  task automatic xfer(input logic [31:0] d, input string tag);
    bit ok;
    int lat;
    ok = 1'b0;
    in_data = d;
    in_stb = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (ack_a) ok = 1'b1;
      tick();
    end
    in_stb = 1'b0;
    chk({tag, "_accept"}, 32'(ok), 32'd1);
    lat = 0;
    while (!stb_a && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd2);
  endtask

  task automatic ack_out();
    z_ack = 1'b1;
    tick();
    z_ack = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();
    chk("rst_ack", 32'(ack_a), 32'd1);
    chk("rst_stb", 32'(stb_a), 32'd0);
    chk("rst_z", z_a, 32'd0);
    chk("rst_sat", 32'(sat_a), 32'd0);
    chk("rst_sat_b", 32'(sat_b), 32'd0);

    xfer(32'd1000, "step1");
    chk("step1_z", z_a, 32'd980);
    ack_out();
    xfer(32'd1000, "step2");
    chk("step2_z", z_a, 32'd960);
    chk("step_sat", 32'(sat_a), 32'd0);
    ack_out();

    do_reset();
    xfer(-32'sd1000, "neg");
    chk("neg_z", z_a, -32'sd981);
    ack_out();

    do_reset();
    xfer(32'd1000, "stall");
    chk("stall_z0", z_a, 32'd980);
    in_data = 32'd1000;
    in_stb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_stb", 32'(stb_a), 32'd1);
      chk("stall_z", z_a, 32'd980);
      chk("stall_ack", 32'(ack_a), 32'd0);
    end
    in_stb = 1'b0;
    ack_out();
    chk("stall_ack_back", 32'(ack_a), 32'd1);
    chk("stall_stb_drop", 32'(stb_a), 32'd0);
    xfer(32'd1000, "stall2");
    chk("stall2_z", z_a, 32'd960);
    ack_out();

    do_reset();
    xfer(32'h80000000, "sat1");
    chk("sat1_z", z_b, 32'h7FFFFFFF);
    chk("sat1_flag", 32'(sat_b), 32'd1);
    chk("sat1_za", z_a, -32'sd2104557568);
    chk("sat1_flag_a", 32'(sat_a), 32'd0);
    ack_out();
    xfer(32'h80000000, "sat2");
    chk("sat2_z", z_b, 32'h80000001);
    chk("sat2_flag", 32'(sat_b), 32'd1);
    ack_out();
    xfer(32'd0, "sat3");
    chk("sat3_z", z_b, 32'hFFFFFFFF);
    chk("sat3_flag", 32'(sat_b), 32'd1);
    ack_out();
    do_reset();
    chk("sat_clr", 32'(sat_b), 32'd0);

    xfer(32'd1000, "mid");
    chk("mid_z", z_a, 32'd980);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_stb", 32'(stb_a), 32'd0);
    chk("mid_ack", 32'(ack_a), 32'd1);
    chk("mid_zrst", z_a, 32'd0);
    xfer(32'd1000, "mid2");
    chk("mid2_z", z_a, 32'd980);
    ack_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
